// File: rtl/value_store_if.sv
// Handshake bundle between the value extractor (write side), the value store
// and the field dispatcher (read side), plus the store's status flags.
interface value_store_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH/8)+1
);
  logic                  clear_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic [LEN_WIDTH-1:0]  wr_len_i;
  logic                  wr_last_i;
  logic                  rd_en_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [LEN_WIDTH-1:0]  rd_len_o;
  logic                  rd_valid_o;
  logic                  rd_err_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  locked_o;
  logic                  msg_done_o;
  logic                  overflow_o;

  modport master (
    output clear_i, wr_en_i, wr_data_i, wr_len_i, wr_last_i, rd_en_i, rd_addr_i,
    input  rd_data_o, rd_len_o, rd_valid_o, rd_err_o,
    input  count_o, full_o, empty_o, locked_o, msg_done_o, overflow_o
  );

  modport slave (
    input  clear_i, wr_en_i, wr_data_i, wr_len_i, wr_last_i, rd_en_i, rd_addr_i,
    output rd_data_o, rd_len_o, rd_valid_o, rd_err_o,
    output count_o, full_o, empty_o, locked_o, msg_done_o, overflow_o
  );
endinterface

// File: rtl/value_store_ctrl.sv
// Per-message FIX field value store: append-only writes with lock on the last
// value, random-access length-masked reads with 1 or 2 cycle latency.
module value_store_byte_mask #(
  parameter int LEN_WIDTH = 6,
  parameter int IDX       = 0
) (
  input  logic [7:0]           byte_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic [7:0]           byte_o
);
  localparam logic [LEN_WIDTH-1:0] IDX_L = LEN_WIDTH'(IDX);

  assign byte_o = (len_i > IDX_L) ? byte_i : 8'h00;
endmodule

module value_store_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH/8)+1,
  parameter int OUT_REG    = 0
) (
  input logic          clk,
  input logic          rst,
  value_store_if.slave vs
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] NBYTES_C = LEN_WIDTH'(NBYTES);

  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [LEN_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] data;
  } rd_rsp_t;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [LEN_WIDTH-1:0]  mem_len  [DEPTH];

  logic [DEPTH-1:0]    valid_q,  valid_d;
  logic [ADDR_WIDTH:0] cnt_q,    cnt_d;
  logic                full_q,   full_d;
  logic                empty_q,  empty_d;
  logic                locked_q, locked_d;
  logic                ovf_q,    ovf_d;
  logic                done_q,   done_d;

  logic                  wr_acc, wr_ref;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [LEN_WIDTH-1:0]  wr_len_c;

  // The write pointer is the entry count: the store never wraps or pops.
  assign wr_acc   = vs.wr_en_i & ~full_q & ~locked_q & ~vs.clear_i;
  assign wr_ref   = vs.wr_en_i & (full_q | locked_q) & ~vs.clear_i;
  assign wr_idx   = cnt_q[ADDR_WIDTH-1:0];
  assign wr_len_c = (vs.wr_len_i > NBYTES_C) ? NBYTES_C : vs.wr_len_i;

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (vs.clear_i) begin
      valid_d  = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else if (wr_acc) begin
      valid_d[wr_idx] = 1'b1;
      cnt_d           = cnt_q + 1'b1;
      locked_d        = vs.wr_last_i;
      done_d          = vs.wr_last_i;
    end else if (wr_ref) begin
      ovf_d = 1'b1;
    end
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_data[wr_idx] <= vs.wr_data_i;
      mem_len[wr_idx]  <= wr_len_c;
    end
  end

  logic [ADDR_WIDTH-1:0]        rd_idx;
  logic                         rd_hit;
  logic [NBYTES-1:0][7:0]       rd_raw, rd_masked;
  logic [LEN_WIDTH-1:0]         rd_len_raw;
  rd_rsp_t                      rsp_d;
  rd_rsp_t                      rsp_q [STAGES];

  // Reads see registered valid bits and memory, so a same-cycle write or
  // clear is invisible to them (read-before-write).
  assign rd_idx     = vs.rd_addr_i;
  assign rd_hit     = valid_q[rd_idx];
  assign rd_raw     = mem_data[rd_idx];
  assign rd_len_raw = mem_len[rd_idx];

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    value_store_byte_mask #(.LEN_WIDTH(LEN_WIDTH), .IDX(b)) u_mask (
      .byte_i (rd_raw[b]),
      .len_i  (rd_len_raw),
      .byte_o (rd_masked[b])
    );
  end

  always_comb begin
    rsp_d = '0;
    if (vs.rd_en_i) begin
      rsp_d.vld = 1'b1;
      rsp_d.err = ~rd_hit;
      if (rd_hit) begin
        rsp_d.len  = rd_len_raw;
        rsp_d.data = rd_masked;
      end
    end
  end

  // Idle slots carry all-zero responses, so outputs read 0 between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < STAGES; s++) rsp_q[s] <= '0;
    end else begin
      rsp_q[0] <= rsp_d;
      for (int s = 1; s < STAGES; s++) rsp_q[s] <= rsp_q[s-1];
    end
  end

  assign vs.rd_valid_o = rsp_q[STAGES-1].vld;
  assign vs.rd_err_o   = rsp_q[STAGES-1].err;
  assign vs.rd_len_o   = rsp_q[STAGES-1].len;
  assign vs.rd_data_o  = rsp_q[STAGES-1].data;
  assign vs.count_o    = cnt_q;
  assign vs.full_o     = full_q;
  assign vs.empty_o    = empty_q;
  assign vs.locked_o   = locked_q;
  assign vs.msg_done_o = done_q;
  assign vs.overflow_o = ovf_q;
endmodule

// File: tb/tb_value_store_ctrl.sv
// Randomised scoreboard bench for value_store_ctrl, OUT_REG=0 and OUT_REG=1
// instances driven in lockstep against a queue-based store model.
module tb_value_store_ctrl;
  localparam int AW = 5, DW = 256, LW = 6, DEPTH = 32, NB = 32, CW = 264;

  typedef struct { int due; logic [DW-1:0] data; logic [LW-1:0] len; logic err; } exp_t;
  typedef struct { logic [DW-1:0] data; int len; } ent_t;

  logic clk = 1'b0, rst = 1'b1, mon_en = 1'b0;
  int   cyc = 0, checks = 0, errors = 0;

  logic          clear, wr_en, wr_last, rd_en;
  logic [DW-1:0] wr_data;
  logic [LW-1:0] wr_len;
  logic [AW-1:0] rd_addr;

  ent_t ents[$];
  bit   m_locked, m_ovf, m_done;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  value_store_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) vi0 ();
  value_store_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) vi1 ();

  assign vi0.clear_i = clear;   assign vi1.clear_i = clear;
  assign vi0.wr_en_i = wr_en;   assign vi1.wr_en_i = wr_en;
  assign vi0.wr_data_i = wr_data; assign vi1.wr_data_i = wr_data;
  assign vi0.wr_len_i = wr_len; assign vi1.wr_len_i = wr_len;
  assign vi0.wr_last_i = wr_last; assign vi1.wr_last_i = wr_last;
  assign vi0.rd_en_i = rd_en;   assign vi1.rd_en_i = rd_en;
  assign vi0.rd_addr_i = rd_addr; assign vi1.rd_addr_i = rd_addr;

  value_store_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .vs(vi0));
  value_store_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .vs(vi1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lenmask(input int n);
    logic [DW-1:0] ones = '1;
    return (n >= NB) ? ones : ~(ones << (8*n));
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // status vector: {count, full, empty, locked, overflow, msg_done}
  task automatic chk_status();
    logic [CW-1:0] exp;
    exp = CW'({6'(ents.size()), ents.size() == DEPTH, ents.size() == 0, m_locked, m_ovf, m_done});
    chk("status0", CW'({vi0.count_o, vi0.full_o, vi0.empty_o, vi0.locked_o, vi0.overflow_o, vi0.msg_done_o}), exp);
    chk("status1", CW'({vi1.count_o, vi1.full_o, vi1.empty_o, vi1.locked_o, vi1.overflow_o, vi1.msg_done_o}), exp);
  endtask

  task automatic model_reset();
    ents.delete();
    m_locked = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic step(input bit clr, input bit we, input logic [DW-1:0] wd, input int wl,
                      input bit last, input bit re, input int ra);
    exp_t e;
    bit   acc_last;
    @(negedge clk);
    chk_status();
    clear = clr; wr_en = we; wr_data = wd; wr_len = LW'(wl); wr_last = last;
    rd_en = re; rd_addr = AW'(ra);
    if (re) begin
      if (ra < ents.size()) begin
        e.data = ents[ra].data & lenmask(ents[ra].len);
        e.len  = LW'(ents[ra].len);
        e.err  = 1'b0;
      end else begin
        e.data = '0; e.len = '0; e.err = 1'b1;
      end
      e.due = cyc + 1; q0.push_back(e);
      e.due = cyc + 2; q1.push_back(e);
    end
    acc_last = 0;
    if (clr) begin
      ents.delete(); m_locked = 0; m_ovf = 0;
    end else if (we) begin
      if (ents.size() == DEPTH || m_locked) m_ovf = 1;
      else begin
        ents.push_back('{wd, (wl > NB) ? NB : wl});
        if (last) begin m_locked = 1; acc_last = 1; end
      end
    end
    m_done = acc_last;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int wl, input bit last);
    step(0, 1, rnd256(), wl, last, 0, 0);
  endtask

  task automatic rd(input int ra);
    step(0, 0, '0, 0, 0, 1, ra);
  endtask

  always @(negedge clk) if (mon_en) begin
    if (q0.size() != 0 && q0[0].due == cyc) begin
      e0 = q0.pop_front();
      chk("rd0", {vi0.rd_valid_o, vi0.rd_err_o, vi0.rd_len_o, vi0.rd_data_o}, {1'b1, e0.err, e0.len, e0.data});
    end else
      chk("idle0", {vi0.rd_valid_o, vi0.rd_err_o, vi0.rd_len_o, vi0.rd_data_o}, '0);
  end

  always @(negedge clk) if (mon_en) begin
    if (q1.size() != 0 && q1[0].due == cyc) begin
      e1 = q1.pop_front();
      chk("rd1", {vi1.rd_valid_o, vi1.rd_err_o, vi1.rd_len_o, vi1.rd_data_o}, {1'b1, e1.err, e1.len, e1.data});
    end else
      chk("idle1", {vi1.rd_valid_o, vi1.rd_err_o, vi1.rd_len_o, vi1.rd_data_o}, '0);
  end

  initial begin
    clear = 0; wr_en = 0; wr_data = '0; wr_len = '0; wr_last = 0; rd_en = 0; rd_addr = '0;
    model_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk_status();
    rst = 1'b1;

    // three values, then reads 0..3 back-to-back
    wr(4, 0); wr(32, 0); wr(0, 0);
    rd(0); rd(1); rd(2); rd(3);
    idle(); idle();

    // length clamp
    step(1, 0, '0, 0, 0, 0, 0);
    wr(40, 0); rd(0); idle();

    // fill, then one refused write
    step(1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) wr($urandom_range(0, 32), 0);
    wr(8, 0);
    rd(0); rd(31); idle(); idle();

    // lock on last, refused write, clear
    step(1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) wr(7, i == 4);
    wr(3, 0);
    idle();
    step(1, 0, '0, 0, 0, 0, 0);
    rd(0); idle();

    // same-cycle read/write on empty store, then same-cycle clear and write
    step(0, 1, rnd256(), 20, 0, 1, 0);
    rd(0);
    step(1, 1, rnd256(), 9, 0, 0, 0);
    idle(); idle();

    // continuous reads 0..7, then reset with a read in flight
    for (int i = 0; i < 8; i++) wr(4 * i + 1, 0);
    for (int i = 0; i < 8; i++) rd(i);
    rd(5);
    @(negedge clk);
    #1;
    clear = 0; wr_en = 0; wr_last = 0; rd_en = 0;
    rst = 1'b0;
    q1.delete();
    model_reset();
    repeat (2) @(negedge clk);
    chk_status();
    rst = 1'b1;
    rd(0); idle();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 6, 1'($urandom_range(0, 1)), rnd256(), $urandom_range(0, 40),
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31));
    end

    idle(); idle(); idle();
    @(negedge clk);
    chk_status();
    chk("drain0", CW'(q0.size()), '0);
    chk("drain1", CW'(q1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
